// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_display_ctrl
// Purpose  : Seven-segment controller with static per-digit outputs and a
//            multiplexed scan bus; blanking, blinking, raw mode, polarity.
//            Optional leading-zero blanking when SEG7_LZB_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_en,
  input  logic [4*NUM_DIGITS-1:0] i_wr_data,
  input  logic                    i_cfg_en,
  input  logic [NUM_DIGITS-1:0]   i_cfg_blank,
  input  logic [NUM_DIGITS-1:0]   i_cfg_blink,
  input  logic                    i_cfg_raw,
  output logic [7*NUM_DIGITS-1:0] o_io_hex,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_dig_sel,
  output logic [2:0]              o_scan_idx
);

  localparam int                    c_SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int                    c_BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_SCAN_W-1:0]   c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_BLINK_W-1:0]  c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
  localparam logic [2:0]            c_IDX_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [6:0]            c_BLANK     = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  c_SEL_ON    = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [NUM_DIGITS-1:0] c_SEL_RESET = (ACTIVE_LOW != 0) ? ~NUM_DIGITS'(1)
                                                                    : NUM_DIGITS'(1);

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_blink;
  logic                    r_raw;
  logic [c_SCAN_W-1:0]     r_scan_cnt;
  logic [2:0]              r_scan_idx;
  logic [c_BLINK_W-1:0]    r_blink_cnt;
  logic                    r_blink_phase;
  logic [7*NUM_DIGITS-1:0] r_io_hex;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig_sel;

  logic                    w_scan_wrap;
  logic [c_SCAN_W-1:0]     w_scan_cnt_next;
  logic [2:0]              w_idx_next;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [7*NUM_DIGITS-1:0] w_hex_next;
  logic [6:0]              w_seg_next;
  logic [NUM_DIGITS-1:0]   w_sel_next;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= '0;
      r_blank <= '0;
      r_blink <= '0;
      r_raw   <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_value <= i_wr_data;
      end
      if (i_cfg_en) begin
        r_blank <= i_cfg_blank;
        r_blink <= i_cfg_blink;
        r_raw   <= i_cfg_raw;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == c_BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + c_BLINK_W'(1);
    end
  end

  always_comb begin
    w_scan_wrap     = (r_scan_cnt == c_SCAN_LAST);
    w_scan_cnt_next = w_scan_wrap ? '0 : r_scan_cnt + c_SCAN_W'(1);
    if (!w_scan_wrap) begin
      w_idx_next = r_scan_idx;
    end else if (r_scan_idx == c_IDX_LAST) begin
      w_idx_next = 3'd0;
    end else begin
      w_idx_next = r_scan_idx + 3'd1;
    end
  end

`ifdef SEG7_LZB_EN
  // Digits above the most significant non-zero nibble; digit 0 always shows.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    w_lz       = '0;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      upper_zero = upper_zero & (r_value[4*d +: 4] == 4'h0);
      w_lz[d]    = upper_zero & ~r_raw;
    end
  end
`else
  assign w_lz = '0;
`endif

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [6:0] w_raw_seg;
    logic [6:0] w_lit;
    logic       w_off;

    // Raw mode consumes a byte per digit, so only the lower half can be fed.
    if (d < NUM_DIGITS / 2) begin : g_raw_src
      assign w_raw_seg = r_value[8*d +: 7];
    end else begin : g_raw_none
      assign w_raw_seg = 7'h00;
    end

    assign w_lit = r_raw ? w_raw_seg : hex_decode(r_value[4*d +: 4]);
    assign w_off = r_blank[d] | w_lz[d] | (r_blink[d] & r_blink_phase);
    assign w_hex_next[7*d +: 7] = w_off ? c_BLANK
                                        : ((ACTIVE_LOW != 0) ? ~w_lit : w_lit);
  end

  // Scan bus is taken from the same next-state pattern as the static pins,
  // so o_seg always equals the o_io_hex slice selected by o_scan_idx.
  always_comb begin
    w_seg_next = c_BLANK;
    w_sel_next = {NUM_DIGITS{~c_SEL_ON}};
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_idx_next == 3'(d)) begin
        w_seg_next    = w_hex_next[7*d +: 7];
        w_sel_next[d] = c_SEL_ON;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scan_cnt <= '0;
      r_scan_idx <= 3'd0;
      r_io_hex   <= {NUM_DIGITS{c_BLANK}};
      r_seg      <= c_BLANK;
      r_dig_sel  <= c_SEL_RESET;
    end else begin
      r_scan_cnt <= w_scan_cnt_next;
      r_scan_idx <= w_idx_next;
      r_io_hex   <= w_hex_next;
      r_seg      <= w_seg_next;
      r_dig_sel  <= w_sel_next;
    end
  end

  assign o_io_hex   = r_io_hex;
  assign o_seg      = r_seg;
  assign o_dig_sel  = r_dig_sel;
  assign o_scan_idx = r_scan_idx;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_display_ctrl
// Purpose  : Directed self-checking bench for seg7_display_ctrl (8 digits,
//            SCAN_DIV=2, BLINK_DIV=4, active-low). Honours SEG7_LZB_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_display_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        cfg_en;
  logic [7:0]  cfg_blank;
  logic [7:0]  cfg_blink;
  logic        cfg_raw;
  logic [55:0] io_hex;
  logic [6:0]  seg;
  logic [7:0]  dig_sel;
  logic [2:0]  scan_idx;

  int checks = 0;
  int passes = 0;

  localparam logic [55:0] ALL_BLANK = {8{7'h7F}};
`ifdef SEG7_LZB_EN
  localparam logic [55:0] ZERO_HEX  = {{7{7'h7F}}, 7'h40};
  localparam logic [55:0] EXP_WR    = {7'h7F, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h0E};
  localparam logic [6:0]  D1_ZERO   = 7'h7F;
  localparam logic [55:0] EXP_A0    = {{6{7'h7F}}, 7'h08, 7'h40};
`else
  localparam logic [55:0] ZERO_HEX  = {8{7'h40}};
  localparam logic [55:0] EXP_WR    = {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h0E};
  localparam logic [6:0]  D1_ZERO   = 7'h40;
  localparam logic [55:0] EXP_A0    = {{6{7'h40}}, 7'h08, 7'h40};
`endif

  seg7_display_ctrl #(
    .NUM_DIGITS(8), .SCAN_DIV(2), .BLINK_DIV(4), .ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_cfg_en(cfg_en), .i_cfg_blank(cfg_blank), .i_cfg_blink(cfg_blink),
    .i_cfg_raw(cfg_raw), .o_io_hex(io_hex), .o_seg(seg),
    .o_dig_sel(dig_sel), .o_scan_idx(scan_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d checks=%0d", passes, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the last reset edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; cfg_en = 1'b0;
    cfg_blank = '0; cfg_blink = '0; cfg_raw = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; cfg_en = 1'b0;
    cfg_blank = '0; cfg_blink = '0; cfg_raw = 1'b0;
    tick();
    checks++; if (io_hex !== ALL_BLANK) $display("FAIL reset_hex: got %h want %h", io_hex, ALL_BLANK); else passes++;
    checks++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg); else passes++;
    checks++; if (dig_sel !== 8'hFE) $display("FAIL reset_dig_sel: got %h want fe", dig_sel); else passes++;
    checks++; if (scan_idx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", scan_idx); else passes++;
    rst_n = 1'b1;
    tick();
    checks++; if (io_hex !== ZERO_HEX) $display("FAIL release_hex: got %h want %h", io_hex, ZERO_HEX); else passes++;
    checks++; if (seg !== 7'h40) $display("FAIL release_seg: got %h want 40", seg); else passes++;
    tick();
    checks++; if (scan_idx !== 3'd1) $display("FAIL release_idx: got %0d want 1", scan_idx); else passes++;
    checks++; if (dig_sel !== 8'hFD) $display("FAIL release_dig_sel: got %h want fd", dig_sel); else passes++;
  endtask

  task automatic test_write();
    logic [55:0] exp2;
    do_reset();
    wr_data = 32'h0123ABCF; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++; if (io_hex !== ZERO_HEX) $display("FAIL write_latency: got %h want %h", io_hex, ZERO_HEX); else passes++;
    tick();
    checks++; if (io_hex !== EXP_WR) $display("FAIL write_hex: got %h want %h", io_hex, EXP_WR); else passes++;
    // value and mask captured in the same cycle
    exp2 = {7'h12, {5{7'h40}}, 7'h7F, 7'h12};
    wr_data = 32'h50000005; wr_en = 1'b1; cfg_en = 1'b1; cfg_blank = 8'h02;
    tick();
    wr_en = 1'b0; cfg_en = 1'b0;
    checks++; if (io_hex !== EXP_WR) $display("FAIL b2b_latency: got %h want %h", io_hex, EXP_WR); else passes++;
    tick();
    checks++; if (io_hex !== exp2) $display("FAIL b2b_hex: got %h want %h", io_hex, exp2); else passes++;
  endtask

  task automatic test_blink();
    logic [6:0] exp_d0;
    do_reset();
    cfg_en = 1'b1; cfg_blink = 8'h01;
    for (int n = 1; n <= 16; n++) begin
      tick();
      cfg_en = 1'b0;
      if (n >= 2) begin
        exp_d0 = ((((n - 1) / 4) % 2) == 1) ? 7'h7F : 7'h40;
        checks++; if (io_hex[6:0] !== exp_d0) $display("FAIL blink_d0 n=%0d: got %h want %h", n, io_hex[6:0], exp_d0); else passes++;
        checks++; if (io_hex[13:7] !== D1_ZERO) $display("FAIL blink_d1 n=%0d: got %h want %h", n, io_hex[13:7], D1_ZERO); else passes++;
      end
    end
    cfg_en = 1'b1; cfg_blank = 8'h01;
    tick();
    cfg_en = 1'b0;
    for (int n = 0; n < 9; n++) begin
      tick();
      checks++; if (io_hex[6:0] !== 7'h7F) $display("FAIL blank_over_blink n=%0d: got %h want 7f", n, io_hex[6:0]); else passes++;
    end
  endtask

  task automatic test_scan();
    logic [55:0] ew;
    logic [7:0]  es;
    int          idx;
    ew = EXP_WR;
    do_reset();
    wr_data = 32'h0123ABCF; wr_en = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      tick();
      wr_en = 1'b0;
      idx = (n / 2) % 8;
      es  = ~(8'd1 << idx);
      checks++; if (scan_idx !== 3'(idx)) $display("FAIL scan_idx n=%0d: got %0d want %0d", n, scan_idx, idx); else passes++;
      checks++; if (dig_sel !== es) $display("FAIL scan_dig_sel n=%0d: got %h want %h", n, dig_sel, es); else passes++;
      if (n >= 2) begin
        checks++; if (seg !== ew[7*idx +: 7]) $display("FAIL scan_seg n=%0d: got %h want %h", n, seg, ew[7*idx +: 7]); else passes++;
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg_en = 1'b1; cfg_blink = 8'hFF;
    for (int n = 1; n <= 10; n++) begin
      tick();
      cfg_en = 1'b0;
    end
    checks++; if (scan_idx !== 3'd5) $display("FAIL pre_reset_idx: got %0d want 5", scan_idx); else passes++;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (io_hex !== ALL_BLANK) $display("FAIL async_hex: got %h want %h", io_hex, ALL_BLANK); else passes++;
    checks++; if (seg !== 7'h7F) $display("FAIL async_seg: got %h want 7f", seg); else passes++;
    checks++; if (dig_sel !== 8'hFE) $display("FAIL async_dig_sel: got %h want fe", dig_sel); else passes++;
    checks++; if (scan_idx !== 3'd0) $display("FAIL async_idx: got %0d want 0", scan_idx); else passes++;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (scan_idx !== 3'd0) $display("FAIL restart_idx0: got %0d want 0", scan_idx); else passes++;
    checks++; if (io_hex !== ZERO_HEX) $display("FAIL restart_hex: got %h want %h", io_hex, ZERO_HEX); else passes++;
    tick();
    checks++; if (scan_idx !== 3'd1) $display("FAIL restart_idx1: got %0d want 1", scan_idx); else passes++;
  endtask

  task automatic test_raw();
    logic [55:0] exp_raw;
    exp_raw = {{5{7'h7F}}, 7'h00, 7'h79, 7'h40};
    do_reset();
    cfg_en = 1'b1; cfg_raw = 1'b1; wr_en = 1'b1; wr_data = 32'h007F063F;
    tick();
    cfg_en = 1'b0; wr_en = 1'b0;
    tick();
    checks++; if (io_hex !== exp_raw) $display("FAIL raw_hex: got %h want %h", io_hex, exp_raw); else passes++;
  endtask

  task automatic test_lzb();
    do_reset();
    wr_data = 32'h000000A0; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    checks++; if (io_hex !== EXP_A0) $display("FAIL lzb_a0: got %h want %h", io_hex, EXP_A0); else passes++;
    wr_data = 32'h0; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    checks++; if (io_hex !== ZERO_HEX) $display("FAIL lzb_zero: got %h want %h", io_hex, ZERO_HEX); else passes++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_blink();
    test_scan();
    test_async_reset();
    test_raw();
    test_lzb();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
